// File: rtl/quiz_master.sv
// ============================================================================
// Module   : quiz_master
// Brief    : N-player quiz buzzer: first-press arbitration, answer countdown,
//            timeout alarm and saturating per-player scores. Optional macro
//            FALSE_START_EN adds false-start disqualification.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quiz_master #(
    parameter int N_PLAYERS  = 4,
    parameter int CLK_HZ     = 12000000,
    parameter int ANSWER_SEC = 30,
    parameter int SCORE_INIT = 5,
    parameter int SCORE_MAX  = 9,
    parameter int SCORE_W    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              reset_scores,
    input  logic                              add,
    input  logic                              sub,
    input  logic [N_PLAYERS-1:0]              key,
    output logic [N_PLAYERS-1:0]              winner_led,
    output logic [$clog2(N_PLAYERS)-1:0]      winner_id,
    output logic                              winner_valid,
    output logic [$clog2(ANSWER_SEC+1)-1:0]   time_left,
    output logic                              buzz,
    output logic [N_PLAYERS*SCORE_W-1:0]      scores
`ifdef FALSE_START_EN
    ,
    output logic [N_PLAYERS-1:0]              false_start
`endif
);

    localparam int c_ID_W = $clog2(N_PLAYERS);
    localparam int c_T_W  = $clog2(ANSWER_SEC + 1);
    localparam int c_P_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [c_P_W-1:0]   c_P_TC       = c_P_W'(CLK_HZ - 1);
    localparam logic [c_T_W-1:0]   c_TIME_INIT  = c_T_W'(ANSWER_SEC);
    localparam logic [SCORE_W-1:0] c_SCORE_INIT = SCORE_W'(SCORE_INIT);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX  = SCORE_W'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LOCKED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t                 r_state;
    logic [N_PLAYERS-1:0]   r_sync1, r_sync2, r_sync3;
    logic [c_P_W-1:0]       r_presc;
    logic [c_T_W-1:0]       r_time;
    logic                   r_buzz;
    logic                   r_valid;
    logic [c_ID_W-1:0]      r_id;
    logic [N_PLAYERS-1:0]   r_led;
    logic [SCORE_W-1:0]     r_score [N_PLAYERS];
    logic [N_PLAYERS-1:0]   r_disq;

    logic [N_PLAYERS-1:0]   w_rise;
    logic [N_PLAYERS-1:0]   w_cand;
    logic                   w_any;
    logic [c_ID_W-1:0]      w_win_id;
    logic                   w_score_op;
    logic                   w_leave_armed;

    assign w_rise = r_sync2 & ~r_sync3;
`ifdef FALSE_START_EN
    assign w_cand = w_rise & ~r_disq;
    assign false_start = r_disq;
`else
    assign w_cand = w_rise;
`endif
    assign w_any = |w_cand;

    // Descending scan so the lowest pressed index is the last one written.
    always_comb begin
        w_win_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_id = c_ID_W'(i);
            end
        end
    end

    assign w_score_op    = (r_state == S_LOCKED) && !start && (r_time != '0) && (add ^ sub);
    assign w_leave_armed = (r_state == S_ARMED) && !start && ((r_time == '0) || w_any);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_time  <= '0;
            r_buzz  <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_led   <= '0;
        end else if (start) begin
            r_state <= S_ARMED;
            r_presc <= '0;
            r_time  <= c_TIME_INIT;
            r_buzz  <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_led   <= '0;
        end else begin
            case (r_state)
                S_ARMED, S_LOCKED: begin
                    if (r_time == '0) begin
                        r_state <= S_TIMEOUT;
                        r_buzz  <= 1'b1;
                    end else if (r_state == S_ARMED && w_any) begin
                        r_state <= S_LOCKED;
                        r_presc <= '0;
                        r_time  <= c_TIME_INIT;
                        r_valid <= 1'b1;
                        r_id    <= w_win_id;
                        r_led   <= N_PLAYERS'(1) << w_win_id;
                    end else if (r_state == S_LOCKED && (add || sub)) begin
                        r_state <= S_IDLE;
                    end else if (r_presc == c_P_TC) begin
                        r_presc <= '0;
                        r_time  <= r_time - 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_score[i] <= c_SCORE_INIT;
            end
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (reset_scores) begin
                    r_score[i] <= c_SCORE_INIT;
                end else if (w_score_op && r_id == c_ID_W'(i)) begin
                    if (add && r_score[i] < c_SCORE_MAX) begin
                        r_score[i] <= r_score[i] + 1'b1;
                    end else if (sub && r_score[i] != '0) begin
                        r_score[i] <= r_score[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Presses while idle mark the player; the marks drop once arbitration ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disq <= '0;
        end else if (w_leave_armed) begin
            r_disq <= '0;
        end else if (r_state == S_IDLE) begin
            r_disq <= r_disq | w_rise;
        end
    end

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_score
            assign scores[gi*SCORE_W +: SCORE_W] = r_score[gi];
        end
    endgenerate

    assign winner_led   = r_led;
    assign winner_id    = r_id;
    assign winner_valid = r_valid;
    assign time_left    = r_time;
    assign buzz         = r_buzz;

`ifndef FALSE_START_EN
    logic w_unused;
    assign w_unused = ^r_disq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quiz_master.sv
// ============================================================================
// Module   : tb_quiz_master
// Brief    : Self-checking bench for quiz_master with a rule-level score model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quiz_master;

    localparam int N   = 4;
    localparam int HZ  = 10;
    localparam int SEC = 3;
    localparam int SW  = 4;
    localparam int INIT = 5;
    localparam int MAXS = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           reset_scores = 1'b0;
    logic           add = 1'b0;
    logic           sub = 1'b0;
    logic [N-1:0]   key = '0;
    logic [N-1:0]   winner_led;
    logic [1:0]     winner_id;
    logic           winner_valid;
    logic [1:0]     time_left;
    logic           buzz;
    logic [N*SW-1:0] scores;
`ifdef FALSE_START_EN
    logic [N-1:0]   false_start;
`endif

    quiz_master #(
        .N_PLAYERS (N),
        .CLK_HZ    (HZ),
        .ANSWER_SEC(SEC),
        .SCORE_INIT(INIT),
        .SCORE_MAX (MAXS),
        .SCORE_W   (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reset_scores(reset_scores),
        .add         (add),
        .sub         (sub),
        .key         (key),
        .winner_led  (winner_led),
        .winner_id   (winner_id),
        .winner_valid(winner_valid),
        .time_left   (time_left),
        .buzz        (buzz),
        .scores      (scores)
`ifdef FALSE_START_EN
        ,
        .false_start (false_start)
`endif
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int mscore [N];
    int mwin   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*SW-1:0] exp_scores();
        logic [N*SW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'(mscore[i]);
        return r;
    endfunction

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // op: 0 add, 1 sub, 2 add+sub, 3 reset_scores+add
    task automatic round(input logic [N-1:0] mask, input int dly, input int op, input logic [N-1:0] excl);
        int w;
        pulse_start();
        check("armed_time", 32'(time_left), 32'(SEC));
        check("armed_clear", {winner_valid, winner_led}, 0);
        repeat (dly) @(negedge clk);
        key = mask;
        repeat (2) @(negedge clk);
        check("no_win_t2", 32'(winner_valid), 0);
        @(negedge clk);
        w = lowest(mask & ~excl);
        mwin = w;
        check("win_valid", 32'(winner_valid), 1);
        check("win_id", 32'(winner_id), 32'(w));
        check("win_led", 32'(winner_led), 32'(1 << w));
        check("lock_time", 32'(time_left), 32'(SEC));
        add = (op != 1);
        sub = (op == 1) || (op == 2);
        reset_scores = (op == 3);
        @(negedge clk);
        add = 1'b0; sub = 1'b0; reset_scores = 1'b0;
        case (op)
            0: if (mscore[w] < MAXS) mscore[w]++;
            1: if (mscore[w] > 0) mscore[w]--;
            3: for (int i = 0; i < N; i++) mscore[i] = INIT;
            default: ;
        endcase
        check("scores", 32'(scores), 32'(exp_scores()));
        key = '0;
        repeat (4) @(negedge clk);
        check("idle_hold", {winner_valid, winner_led}, {1'b1, 4'(1 << w)});
        check("idle_scores", 32'(scores), 32'(exp_scores()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) mscore[i] = INIT;

        // Reset state, during and after reset
        @(negedge clk);
        check("rst_outs", {winner_led, winner_id, winner_valid, time_left, buzz}, 0);
        check("rst_scores", 32'(scores), 32'(exp_scores()));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_outs", {winner_led, winner_id, winner_valid, time_left, buzz}, 0);

        // Single press, then a same-cycle tie
        round(4'b0100, 5, 0, '0);
        round(4'b1010, 2, 1, '0);

`ifndef FALSE_START_EN
        // Press in IDLE has no effect
        key = 4'b0001;
        repeat (4) @(negedge clk);
        check("idle_press", {winner_valid, winner_id}, {1'b1, 2'(mwin)});
        key = '0;
        repeat (4) @(negedge clk);
`endif

        // Countdown and timeout
        pulse_start();
        for (int k = 0; k <= SEC * HZ + 1; k++) begin
            int tl;
            tl = SEC - k / HZ;
            if (tl < 0) tl = 0;
            check("countdown", 32'(time_left), 32'(tl));
            check("buzz", 32'(buzz), 32'(k >= SEC * HZ + 1));
            @(negedge clk);
        end
        check("to_hold", {buzz, winner_valid}, 2'b10);
        add = 1'b1;
        @(negedge clk);
        add = 1'b0;
        key = 4'b0010;
        repeat (4) @(negedge clk);
        check("to_add_ignored", 32'(scores), 32'(exp_scores()));
        check("to_press_ignored", {buzz, winner_valid, time_left}, 4'b1000);
        key = '0;
        repeat (4) @(negedge clk);
        pulse_start();
        check("restart", {buzz, winner_valid, time_left}, {2'b00, 2'(SEC)});
        key = 4'b0001;
        repeat (3) @(negedge clk);
        check("restart_win", {winner_valid, winner_id}, 3'b100);
        add = 1'b1; sub = 1'b1;
        @(negedge clk);
        add = 1'b0; sub = 1'b0;
        key = '0;
        check("addsub_same", 32'(scores), 32'(exp_scores()));
        repeat (4) @(negedge clk);

        // Saturation on player 0
        for (int r = 0; r < 6; r++) round(4'b0001, 1, 0, '0);
        for (int r = 0; r < 11; r++) round(4'b1001, 0, 1, '0);

        // reset_scores overrides add
        round(4'b0110, 3, 3, '0);

        // Randomized rounds
        for (int r = 0; r < 10; r++)
            round(4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 3), '0);

`ifdef FALSE_START_EN
        key = 4'b0001;
        repeat (4) @(negedge clk);
        check("fs_set", 32'(false_start), 32'b0001);
        key = '0;
        repeat (4) @(negedge clk);
        pulse_start();
        key = 4'b0001;
        repeat (4) @(negedge clk);
        check("fs_ignored", 32'(winner_valid), 0);
        key = 4'b0011;
        repeat (3) @(negedge clk);
        check("fs_win", {winner_valid, winner_id}, 3'b101);
        check("fs_clear", 32'(false_start), 0);
        key = '0;
        repeat (4) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
